// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_pkg
// Purpose  : Shared SPI definitions for the controller and target blocks.
// Revision : 1.0
// ============================================================================
package spi_pkg;

    // Target-side state machine
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DONE   = 2'd2
    } spi_tgt_state_e;

    // Controller-side state machine
    typedef enum logic [1:0] {
        CTRL_IDLE  = 2'd0,
        CTRL_LEAD  = 2'd1,
        CTRL_TRAIL = 2'd2,
        CTRL_END   = 2'd3
    } spi_ctrl_state_e;

    localparam int unsigned FRAME_LEN_8     = 8;
    localparam int unsigned FRAME_LEN_16    = 16;
    localparam int unsigned CTRL_CLKDIV_MIN = 2;
    localparam logic [4:0]  BIT_CNT_MAX     = 5'd31;

    function automatic logic [4:0] frame_len(input logic width8);
        return width8 ? 5'(FRAME_LEN_8) : 5'(FRAME_LEN_16);
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_sync_edge.sv
`default_nettype none
// ============================================================================
// Module   : spi_sync_edge
// Purpose  : Multi-flop synchronizer with one-cycle rise/fall pulse outputs.
// Revision : 1.0
// ============================================================================
module spi_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic rst_val_i,
    input  logic async_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    // Reset to the line's idle level so no edge is reported on release
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {STAGES{rst_val_i}};
            prev_q <= rst_val_i;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], async_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign level_o = sync_q[STAGES-1];
    assign rise_o  = sync_q[STAGES-1] & ~prev_q;
    assign fall_o  = ~sync_q[STAGES-1] & prev_q;

endmodule
`default_nettype wire

// File: rtl/spi_target.sv
`default_nettype none
// ============================================================================
// Module   : spi_target
// Purpose  : SPI target (8/16-bit frames, selectable clock phase), fully
//            oversampled in the system clock domain.
// Revision : 1.0
// ============================================================================
module spi_target
    import spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        SS_n,
    input  logic        SCLK,
    input  logic        MOSI,
    output logic        MISO,
    input  logic        pos_edge,
    input  logic        width8,
    input  logic [15:0] tx_data,
    output logic [15:0] rx_data,
    output logic        rx_valid,
    input  logic        rx_ack,
    output logic        overrun,
    output logic        frame_err,
    output logic        busy
);

    localparam logic [2:0] FLUSH_CYC = 3'(SYNC_STAGES + 1);

    logic w_ss_level, w_ss_rise, w_ss_fall;
    logic w_sclk_level, w_sclk_rise, w_sclk_fall;
    logic w_mosi, w_mosi_rise, w_mosi_fall;
    logic w_unused;

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_ss (
        .clk       (clk),
        .rst       (rst),
        .rst_val_i (1'b1),
        .async_i   (SS_n),
        .level_o   (w_ss_level),
        .rise_o    (w_ss_rise),
        .fall_o    (w_ss_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk       (clk),
        .rst       (rst),
        .rst_val_i (~pos_edge),
        .async_i   (SCLK),
        .level_o   (w_sclk_level),
        .rise_o    (w_sclk_rise),
        .fall_o    (w_sclk_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_mosi (
        .clk       (clk),
        .rst       (rst),
        .rst_val_i (1'b0),
        .async_i   (MOSI),
        .level_o   (w_mosi),
        .rise_o    (w_mosi_rise),
        .fall_o    (w_mosi_fall)
    );

    assign w_unused = ^{w_sclk_level, w_mosi_rise, w_mosi_fall};

    logic       w_sample;
    logic       w_shift;
    logic       w_good;
    logic [4:0] bit_cnt_d;

    spi_tgt_state_e state_q;
    logic [15:0]    tx_q;
    logic [15:0]    rx_sh_q;
    logic [4:0]     bit_cnt_q;
    logic [15:0]    rx_data_q;
    logic           rx_valid_q;
    logic           overrun_q;
    logic           frame_err_q;
    logic           busy_q;
    logic           pend_q;
    logic           armed_q;
    logic [2:0]     flush_q;

    assign w_sample  = pos_edge ? w_sclk_rise : w_sclk_fall;
    assign w_shift   = pos_edge ? w_sclk_fall : w_sclk_rise;
    assign w_good    = (bit_cnt_q == frame_len(width8));
    assign bit_cnt_d = (bit_cnt_q == BIT_CNT_MAX) ? bit_cnt_q : bit_cnt_q + 5'd1;

    // After reset the synchronizers hold idle values; wait until they carry the
    // real pin level and only accept frames once SS_n has been seen high, so a
    // frame interrupted by reset is not picked up half-way.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flush_q <= 3'd0;
            armed_q <= 1'b0;
        end else begin
            if (flush_q != FLUSH_CYC) begin
                flush_q <= flush_q + 3'd1;
            end else if (w_ss_level) begin
                armed_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            tx_q        <= 16'h0000;
            rx_sh_q     <= 16'h0000;
            bit_cnt_q   <= 5'd0;
            rx_data_q   <= 16'h0000;
            rx_valid_q  <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
            pend_q      <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            if (rx_ack) begin
                overrun_q <= 1'b0;
            end
            if (rx_ack && rx_valid_q) begin
                rx_valid_q <= 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    pend_q <= 1'b0;
                    if (armed_q && (w_ss_fall || pend_q)) begin
                        state_q   <= ST_ACTIVE;
                        busy_q    <= 1'b1;
                        tx_q      <= tx_data;
                        rx_sh_q   <= 16'h0000;
                        bit_cnt_q <= 5'd0;
                    end
                end

                ST_ACTIVE: begin
                    if (w_ss_rise) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                    end else begin
                        if (w_sample) begin
                            rx_sh_q   <= {rx_sh_q[14:0], w_mosi};
                            bit_cnt_q <= bit_cnt_d;
                        end
                        if (w_shift) begin
                            tx_q <= {tx_q[14:0], 1'b0};
                        end
                    end
                end

                ST_DONE: begin
                    state_q <= ST_IDLE;
                    // A select that drops during the DONE cycle starts the next frame
                    pend_q  <= w_ss_fall;
                    if (w_good) begin
                        rx_data_q  <= width8 ? {8'h00, rx_sh_q[7:0]} : rx_sh_q;
                        rx_valid_q <= 1'b1;
                        if (rx_valid_q && !rx_ack) begin
                            overrun_q <= 1'b1;
                        end
                    end else begin
                        frame_err_q <= 1'b1;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign MISO      = tx_q[15];
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign overrun   = overrun_q;
    assign frame_err = frame_err_q;
    assign busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_target.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_target
// Purpose  : Self-checking bench for spi_target with a bit-banged controller.
// Revision : 1.0
// ============================================================================
module tb_spi_target;

    localparam int HALF = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic        SS_n, SCLK, MOSI, MISO;
    logic        pos_edge, width8;
    logic [15:0] tx_data, rx_data;
    logic        rx_valid, rx_ack, overrun, frame_err, busy;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        pos;
        logic        w8;
        int          nbits;
        logic [15:0] mosi;
        logic [15:0] tx;
        logic        ack_done;
        logic        ack_after;
        logic        pre_valid;
        logic [15:0] exp_data;
        logic        exp_valid;
        logic        exp_ovr;
        logic        exp_ferr;
    } vec_t;

    vec_t vecs[8];
    vec_t exp_q[$];

    spi_target #(.SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .SS_n      (SS_n),
        .SCLK      (SCLK),
        .MOSI      (MOSI),
        .MISO      (MISO),
        .pos_edge  (pos_edge),
        .width8    (width8),
        .tx_data   (tx_data),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ack    (rx_ack),
        .overrun   (overrun),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic pos, input logic w8, input int nbits,
                                input logic [15:0] mosi, input logic [15:0] tx,
                                input logic ack_done, input logic ack_after,
                                input logic pre_valid, input logic [15:0] exp_data,
                                input logic exp_valid, input logic exp_ovr,
                                input logic exp_ferr);
        vec_t v;
        v.pos = pos; v.w8 = w8; v.nbits = nbits; v.mosi = mosi; v.tx = tx;
        v.ack_done = ack_done; v.ack_after = ack_after; v.pre_valid = pre_valid;
        v.exp_data = exp_data; v.exp_valid = exp_valid; v.exp_ovr = exp_ovr;
        v.exp_ferr = exp_ferr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_mode(input logic pos);
        if (pos_edge !== pos) begin
            pos_edge = pos;
            SCLK     = ~pos;
            wait_n(8);
        end
    endtask

    // One controller bit: drive MOSI, sample edge (capture MISO), shift edge
    task automatic xfer_bit(input logic pos, input logic b, output logic m);
        MOSI = b;
        wait_n(HALF);
        SCLK = pos;
        m    = MISO;
        wait_n(HALF);
        SCLK = ~pos;
    endtask

    task automatic run_vec(input vec_t v);
        logic [15:0] got;
        logic        m;
        vec_t        e;
        set_mode(v.pos);
        width8  = v.w8;
        tx_data = v.tx;
        exp_q.push_back(v);
        got = 16'h0000;
        @(negedge clk);
        SS_n = 1'b0;
        for (int i = 0; i < v.nbits; i++) begin
            xfer_bit(v.pos, v.mosi[v.nbits-1-i], m);
            got = {got[14:0], m};
            if (i == 0) chk("busy_active", 16'(busy), 16'h1);
        end
        wait_n(HALF);
        SS_n = 1'b1;
        e = exp_q.pop_front();
        repeat (3) @(posedge clk);
        #1;
        chk("valid_before", 16'(rx_valid), 16'(e.pre_valid));
        if (e.ack_done) rx_ack = 1'b1;
        @(posedge clk);
        #1;
        rx_ack = 1'b0;
        chk("rx_data", rx_data, e.exp_data);
        chk("rx_valid", 16'(rx_valid), 16'(e.exp_valid));
        chk("overrun", 16'(overrun), 16'(e.exp_ovr));
        chk("frame_err", 16'(frame_err), 16'(e.exp_ferr));
        chk("miso_stream", got, e.tx >> (16 - e.nbits));
        @(posedge clk);
        #1;
        chk("frame_err_pulse", 16'(frame_err), 16'h0);
        if (e.ack_after) begin
            @(negedge clk);
            rx_ack = 1'b1;
            @(posedge clk);
            #1;
            rx_ack = 1'b0;
            chk("ack_valid", 16'(rx_valid), 16'h0);
            chk("ack_overrun", 16'(overrun), 16'h0);
        end
        wait_n(4);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic m;
        logic saw;
        logic [15:0] word;

        //           pos w8 n   mosi      tx        ackD ackA pre data      v  ovr ferr
        vecs[0] = mk(1, 0, 16, 16'hA5C3, 16'h3C5A, 0,   0,   0,  16'hA5C3, 1, 0,  0);
        vecs[1] = mk(1, 0, 16, 16'h1234, 16'hBEEF, 0,   1,   1,  16'h1234, 1, 1,  0);
        vecs[2] = mk(0, 1, 8,  16'h0096, 16'hE100, 0,   1,   0,  16'h0096, 1, 0,  0);
        vecs[3] = mk(1, 1, 5,  16'h0016, 16'hA800, 0,   0,   0,  16'h0096, 0, 0,  1);
        vecs[4] = mk(1, 1, 8,  16'h003C, 16'h5A00, 0,   0,   0,  16'h003C, 1, 0,  0);
        vecs[5] = mk(1, 0, 16, 16'h0F0F, 16'h8001, 1,   1,   1,  16'h0F0F, 1, 0,  0);
        vecs[6] = mk(0, 1, 9,  16'h01FF, 16'hC300, 0,   0,   0,  16'h0F0F, 0, 0,  1);
        vecs[7] = mk(0, 0, 16, 16'h7E81, 16'h1111, 0,   0,   0,  16'h7E81, 1, 0,  0);

        rst = 1'b1; SS_n = 1'b1; SCLK = 1'b0; MOSI = 1'b0; pos_edge = 1'b1;
        width8 = 1'b0; tx_data = 16'h0000; rx_ack = 1'b0;
        wait_n(3);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_rx_data", rx_data, 16'h0);
        chk("rst_rx_valid", 16'(rx_valid), 16'h0);
        chk("rst_overrun", 16'(overrun), 16'h0);
        chk("rst_frame_err", 16'(frame_err), 16'h0);
        chk("rst_busy", 16'(busy), 16'h0);
        chk("rst_miso", 16'(MISO), 16'h0);
        wait_n(8);

        for (int k = 0; k < 8; k++) begin
            run_vec(vecs[k]);
        end

        // Reset in the middle of a 16-bit frame
        set_mode(1'b1);
        width8  = 1'b0;
        tx_data = 16'hFFFF;
        word    = 16'hF00D;
        @(negedge clk);
        SS_n = 1'b0;
        for (int i = 0; i < 7; i++) xfer_bit(1'b1, word[15-i], m);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_rx_data", rx_data, 16'h0);
        chk("midrst_rx_valid", 16'(rx_valid), 16'h0);
        chk("midrst_overrun", 16'(overrun), 16'h0);
        chk("midrst_busy", 16'(busy), 16'h0);
        chk("midrst_miso", 16'(MISO), 16'h0);
        rst = 1'b0;
        for (int i = 7; i < 16; i++) xfer_bit(1'b1, word[15-i], m);
        chk("midrst_ignored_busy", 16'(busy), 16'h0);
        wait_n(HALF);
        SS_n = 1'b1;
        saw = 1'b0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (frame_err || rx_valid) saw = 1'b1;
        end
        chk("midrst_tail_quiet", 16'(saw), 16'h0);
        wait_n(4);
        run_vec(mk(1, 0, 16, 16'hC0DE, 16'h5AA5, 0, 0, 0, 16'hC0DE, 1, 0, 0));

        // Select re-asserted during the DONE cycle: second frame must not be lost
        word = 16'h1111;
        @(negedge clk);
        SS_n = 1'b0;
        for (int i = 0; i < 16; i++) xfer_bit(1'b1, word[15-i], m);
        wait_n(HALF);
        SS_n = 1'b1;
        @(negedge clk);
        SS_n = 1'b0;
        word = 16'h2222;
        for (int i = 0; i < 16; i++) xfer_bit(1'b1, word[15-i], m);
        wait_n(HALF);
        SS_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("b2b_rx_data", rx_data, 16'h2222);
        chk("b2b_rx_valid", 16'(rx_valid), 16'h1);
        chk("b2b_overrun", 16'(overrun), 16'h1);
        @(negedge clk);
        rx_ack = 1'b1;
        @(posedge clk);
        #1;
        rx_ack = 1'b0;
        chk("b2b_ack_valid", 16'(rx_valid), 16'h0);
        chk("b2b_ack_overrun", 16'(overrun), 16'h0);
        wait_n(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spi_target.md
SPI_TARGET -- requirements
Module: spi_target

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, the number of input synchronizer flops on SS_n, SCLK and MOSI (legal values 2..3).
REQ-002 SHALL have port clk  input  1  system clock; the only clock in the block.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port SS_n  input  1  frame select from the controller, active low, asynchronous to clk.
REQ-005 SHALL have port SCLK  input  1  serial clock from the controller, asynchronous to clk.
REQ-006 SHALL have port MOSI  input  1  serial data in, MSB first.
REQ-007 SHALL have port MISO  output  1  serial data out, MSB first.
REQ-008 SHALL have port pos_edge  input  1  when 1: sample on SCLK rise, shift on SCLK fall, SCLK idles low; when 0: the inverse, SCLK idles high.
REQ-009 SHALL have port width8  input  1  frame length select: 1 = 8 bits, 0 = 16 bits; must be static while SS_n is low.
REQ-010 SHALL have port tx_data  input  16  response word; bits [15:8] are sent in width8 mode.
REQ-011 SHALL have port rx_data  output  16  last good received word; in width8 mode the word is {8'h00, byte}.
REQ-012 SHALL have port rx_valid  output  1  level; a new rx_data is held.
REQ-013 SHALL have port rx_ack  input  1  consumer acknowledge; clears rx_valid.
REQ-014 SHALL have port overrun  output  1  sticky; a good frame completed while rx_valid was 1.
REQ-015 SHALL have port frame_err  output  1  one-cycle pulse; SS_n rose with a bit count not equal to the frame length.
REQ-016 SHALL have port busy  output  1  state machine is in ACTIVE.

Function
REQ-017 SHALL pass SS_n, SCLK and MOSI through SYNC_STAGES flops each, then one further flop per signal for edge detection.
REQ-018 SHALL require each SCLK high or low phase to last at least SYNC_STAGES+1 clk cycles; this is the controller divider minimum (clkdiv >= 2).
REQ-019 SHALL run a state machine with states IDLE, ACTIVE and DONE.
REQ-020 IDLE -> ACTIVE on a synchronized SS_n falling edge, which also loads tx_data into the TX shift register and clears the bit counter.
REQ-021 Sample edge in ACTIVE: shift synchronized MOSI into the LSB of the RX shift register and increment the 5-bit bit counter.
REQ-022 The bit counter SHALL saturate at 31 rather than wrap around.
REQ-023 Shift edge in ACTIVE: shift the TX register left by one bit with a 0 fill.
REQ-024 MISO SHALL equal TX-register bit 15 at all times, so the first bit is valid before the first sample edge.
REQ-025 ACTIVE -> DONE on a synchronized SS_n rising edge.
REQ-026 DONE -> IDLE unconditionally after one cycle.
REQ-027 In DONE with count == 8 (width8) or 16 (!width8), load rx_data and set rx_valid, both visible on the next cycle.
REQ-028 In DONE with any other count (short or long frame), pulse frame_err and leave rx_data and rx_valid unchanged.
REQ-029 SHALL clear rx_valid the cycle after rx_ack is seen with rx_valid=1.
REQ-030 A good frame in DONE with rx_valid=1 and no rx_ack in the same cycle SHALL set overrun and overwrite rx_data.
REQ-031 A good frame in DONE together with rx_ack in the same cycle SHALL leave rx_valid=1, update rx_data, and not set overrun.
REQ-032 overrun SHALL clear only on rx_ack.
REQ-033 A new SS_n falling edge while in DONE SHALL be honoured from IDLE on the next cycle (no frame lost).
REQ-034 Latency from the synchronized SS_n rising edge to rx_valid=1 SHALL be 2 clk cycles.
REQ-035 SCLK edges while SS_n is high SHALL be ignored.

Reset
REQ-036 On rst=1 (asynchronous): state=IDLE, all shift registers and counters at 0, rx_data=0, rx_valid=0, overrun=0, frame_err=0, busy=0, MISO=0.
REQ-037 Synchronizer flops SHALL reset to the idle values SS_n=1, SCLK=~pos_edge, MOSI=0.
REQ-038 Reset asserted mid-frame SHALL abandon the frame silently; after release, the remainder of that frame is ignored until SS_n rises and falls again.

Structure
REQ-039 The state enum (IDLE, ACTIVE, DONE) and the frame-length constants 8 and 16 SHALL live in the shared SPI package, alongside the controller's definitions.
REQ-040 A single sub-module, spi_sync_edge (parameterised synchronizer with rise/fall pulse outputs), SHALL be instantiated three times.

Verification
REQ-041 pos_edge=1, width8=0, controller sends 16'hA5C3, tx_data=16'h3C5A -> rx_data=16'hA5C3 and rx_valid=1 two cycles after SS_n sync rise; MISO stream = 3C5A.
REQ-042 pos_edge=0, width8=1, controller sends 8'h96, tx_data=16'hE100 -> rx_data=16'h0096; MISO stream = E1.
REQ-043 Two back-to-back 16-bit frames with no rx_ack -> second word in rx_data, overrun=1; rx_ack -> rx_valid=0 and overrun=0 next cycle.
REQ-044 SS_n raised after 5 bits (width8=1) -> one-cycle frame_err, rx_valid stays 0, rx_data unchanged; a following good frame is received correctly.
REQ-045 rst pulsed after bit 7 of a 16-bit frame -> all outputs at reset values; frame_err=0 and rx_valid=0 at that frame's end; next frame correct.
REQ-046 rx_ack asserted in the same cycle as a good-frame DONE with rx_valid=1 -> rx_valid stays 1, rx_data updated, overrun=0.
